// File: rtl/dist_score_pipe.sv
// Purpose : per-pair score = max(a,b) + max(0, OFFSET - SCALE*|a-b|), saturated, summed per frame.
// Latency : 3 cycles from input acceptance to out_valid, 1 pair/cycle.
// Backpr. : in_ready = !out_valid || out_ready; every stage and ans hold while stalled.
//
// Ports:
//   clk, rst               - rising-edge clock, synchronous active-high reset
//   in_valid/in_ready      - input pair handshake, samples in1 (a) and in2 (b)
//   out_valid/out_ready    - score handshake, score on ans
//   frame_sum/frame_valid  - saturated sum of the last complete frame, one-cycle update pulse
//   sample_cnt             - scores accepted downstream in the current frame
module dist_score_pipe #(
   parameter int WIDTH     = 8,
   parameter int SCALE     = 5,    // >= 1
   parameter int OFFSET    = 23,   // < 2**WIDTH
   parameter int FRAME_LEN = 4,    // >= 1
   parameter int ACC_WIDTH = 16,   // >= WIDTH
   localparam int CW       = $clog2(FRAME_LEN) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in1,
   input  logic [WIDTH-1:0]     in2,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     ans,
   output logic [ACC_WIDTH-1:0] frame_sum,
   output logic                 frame_valid,
   output logic [CW-1:0]        sample_cnt
);

   // Product width: SCALE*d can never overflow this, so the clamp compare is exact.
   localparam int PW = WIDTH + $clog2(SCALE) + 1;
   localparam int AX = ACC_WIDTH + 1;
   localparam logic [PW-1:0] SCALE_P  = PW'(SCALE);
   localparam logic [PW-1:0] OFFSET_P = PW'(OFFSET);
   localparam logic [CW-1:0] LAST     = CW'(FRAME_LEN - 1);

   logic                 advance;
   logic                 v1, v2;
   logic [WIDTH-1:0]     a, b;
   logic [WIDTH-1:0]     mx, pen;
   logic [WIDTH-1:0]     mx_c, d_c, pen_c, ans_c;
   logic [PW-1:0]        p_c;
   logic [WIDTH:0]       s_c;
   logic [AX-1:0]        acc_ext;
   logic [ACC_WIDTH-1:0] acc, acc_sum;
   logic                 out_hs;

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;
   assign out_hs   = out_valid && out_ready;

   always_comb begin
      mx_c    = (a > b) ? a : b;
      d_c     = (a > b) ? (a - b) : (b - a);
      p_c     = PW'(d_c) * SCALE_P;
      // Unsigned clamp: penalty only exists while the product is below OFFSET.
      pen_c   = (p_c < OFFSET_P) ? WIDTH'(OFFSET_P - p_c) : '0;
      s_c     = {1'b0, mx} + {1'b0, pen};
      ans_c   = s_c[WIDTH] ? '1 : s_c[WIDTH-1:0];
      acc_ext = {1'b0, acc} + AX'(ans);
      acc_sum = acc_ext[ACC_WIDTH] ? '1 : acc_ext[ACC_WIDTH-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1          <= 1'b0;
         v2          <= 1'b0;
         a           <= '0;
         b           <= '0;
         mx          <= '0;
         pen         <= '0;
         out_valid   <= 1'b0;
         ans         <= '0;
         frame_sum   <= '0;
         frame_valid <= 1'b0;
         sample_cnt  <= '0;
         acc         <= '0;
      end else begin
         // Bubbles move with the data; nothing is compacted.
         if (advance) begin
            v1        <= in_valid;
            a         <= in1;
            b         <= in2;
            v2        <= v1;
            mx        <= mx_c;
            pen       <= pen_c;
            out_valid <= v2;
            ans       <= ans_c;
         end

         frame_valid <= 1'b0;
         if (out_hs) begin
            if (sample_cnt == LAST) begin
               frame_sum   <= acc_sum;
               frame_valid <= 1'b1;
               acc         <= '0;
               sample_cnt  <= '0;
            end else begin
               acc        <= acc_sum;
               sample_cnt <= sample_cnt + CW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_dist_score_pipe.sv
// Bench for dist_score_pipe: default instance plus a WIDTH=12/SCALE=3/OFFSET=100/FRAME_LEN=3 instance.
// Expected scores come from a reference model and travel through per-instance scoreboards.
// Frame sums and sample counts are tracked by a model in each output monitor.
module tb_dist_score_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          cyc = 0;
   int          n_tests = 0;
   int          n_fail = 0;
   bit          mon_en = 1'b0;
   int          acc_cyc = 0;

   // default instance
   logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, frame_valid;
   logic [7:0]  in1 = '0, in2 = '0, ans;
   logic [15:0] frame_sum;
   logic [2:0]  sample_cnt;

   // 12-bit instance
   logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1, b_frame_valid;
   logic [11:0] b_in1 = '0, b_in2 = '0, b_ans;
   logic [15:0] b_frame_sum;
   logic [2:0]  b_sample_cnt;

   int q1[$];
   int q2[$];

   dist_score_pipe dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in1(in1), .in2(in2), .out_valid(out_valid), .out_ready(out_ready),
      .ans(ans), .frame_sum(frame_sum), .frame_valid(frame_valid), .sample_cnt(sample_cnt)
   );

   dist_score_pipe #(.WIDTH(12), .SCALE(3), .OFFSET(100), .FRAME_LEN(3), .ACC_WIDTH(16)) dut_w12 (
      .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in1(b_in1), .in2(b_in2), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .ans(b_ans), .frame_sum(b_frame_sum), .frame_valid(b_frame_valid), .sample_cnt(b_sample_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int score(input int x, input int y, input int w, input int sc, input int off);
      int mx, d, p, pen, s, mx_lim;
      mx     = (x > y) ? x : y;
      d      = (x > y) ? x - y : y - x;
      p      = sc * d;
      pen    = (p < off) ? off - p : 0;
      s      = mx + pen;
      mx_lim = (1 << w) - 1;
      return (s > mx_lim) ? mx_lim : s;
   endfunction

   function automatic int sat16(input int v);
      return (v > 65535) ? 65535 : v;
   endfunction

   // ---------------- output monitors / frame models ----------------
   int  m_acc = 0, m_cnt = 0, exp_fs = 0;
   bit  exp_fv = 0;
   always @(negedge clk) if (mon_en) begin
      int e;
      check_val("frame_valid", frame_valid, exp_fv);
      if (exp_fv) check_val("frame_sum", frame_sum, exp_fs);
      check_val("sample_cnt", sample_cnt, m_cnt);
      exp_fv = 0;
      if (rst) begin
         q1.delete(); m_acc = 0; m_cnt = 0;
      end else if (out_valid && out_ready) begin
         check_val("sb_nonempty", q1.size() != 0, 1);
         if (q1.size() != 0) begin
            e = q1.pop_front();
            check_val("ans", ans, e);
            if (m_cnt == 3) begin
               exp_fs = sat16(m_acc + e); exp_fv = 1; m_acc = 0; m_cnt = 0;
            end else begin
               m_acc = sat16(m_acc + e); m_cnt++;
            end
         end
      end
   end

   int  m2_acc = 0, m2_cnt = 0, exp2_fs = 0;
   bit  exp2_fv = 0;
   always @(negedge clk) if (mon_en) begin
      int e;
      check_val("w12_frame_valid", b_frame_valid, exp2_fv);
      if (exp2_fv) check_val("w12_frame_sum", b_frame_sum, exp2_fs);
      check_val("w12_sample_cnt", b_sample_cnt, m2_cnt);
      exp2_fv = 0;
      if (rst) begin
         q2.delete(); m2_acc = 0; m2_cnt = 0;
      end else if (b_out_valid && b_out_ready) begin
         check_val("w12_sb_nonempty", q2.size() != 0, 1);
         if (q2.size() != 0) begin
            e = q2.pop_front();
            check_val("w12_ans", b_ans, e);
            if (m2_cnt == 2) begin
               exp2_fs = sat16(m2_acc + e); exp2_fv = 1; m2_acc = 0; m2_cnt = 0;
            end else begin
               m2_acc = sat16(m2_acc + e); m2_cnt++;
            end
         end
      end
   end

   // ---------------- driver helpers ----------------
   task automatic send(input int w, input int x, input int y);
      bit ok = 0;
      if (w == 0) begin in1 = 8'(x); in2 = 8'(y); in_valid = 1'b1; end
      else begin b_in1 = 12'(x); b_in2 = 12'(y); b_in_valid = 1'b1; end
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if ((w == 0) ? in_ready : b_in_ready) begin
            if (w == 0) q1.push_back(score(x, y, 8, 5, 23));
            else        q2.push_back(score(x, y, 12, 3, 100));
            acc_cyc = cyc;
            ok = 1;
            break;
         end
      end
      check_val("accept_in_time", ok, 1);
      @(posedge clk); #1;
      in_valid   = 1'b0;
      b_in_valid = 1'b0;
   endtask

   task automatic wait_out(input int w, output int lat);
      bit ok = 0;
      lat = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if ((w == 0) ? out_valid : b_out_valid) begin ok = 1; lat = cyc - acc_cyc; break; end
      end
      check_val("out_in_time", ok, 1);
   endtask

   task automatic drain();
      bit ok = 0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk); #1;
         if (q1.size() == 0 && q2.size() == 0) begin ok = 1; break; end
      end
      check_val("drain_in_time", ok, 1);
      repeat (2) begin @(posedge clk); #1; end
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic wait_cnt(input int w, input int n);
      bit ok = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (((w == 0) ? 32'(sample_cnt) : 32'(b_sample_cnt)) == n) begin ok = 1; break; end
      end
      check_val("cnt_reached", ok, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      int lat, hold;
      repeat (2) begin @(posedge clk); #1; end
      mon_en = 1'b1;
      check_val("rst_out_valid", out_valid, 0);
      check_val("rst_ans", ans, 0);
      check_val("rst_frame_sum", frame_sum, 0);
      check_val("rst_frame_valid", frame_valid, 0);
      check_val("rst_sample_cnt", sample_cnt, 0);
      check_val("rst_w12_out_valid", b_out_valid, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      check_val("in_ready_after_rst", in_ready, 1);

      // first pair and latency
      send(0, 1, 1);
      wait_out(0, lat);
      check_val("latency", lat, 3);
      check_val("first_ans", ans, 24);
      drain();

      // back-to-back, penalty clamp, saturation
      send(0, 1, 0);
      send(0, 200, 10);
      send(0, 250, 245);
      send(0, 250, 249);
      drain();

      // realign the frame, then a full frame 24+19+200+255
      pulse_rst();
      check_val("realign_cnt", sample_cnt, 0);
      send(0, 1, 1);
      send(0, 1, 0);
      send(0, 200, 10);
      send(0, 250, 249);
      drain();
      check_val("frame_498", frame_sum, 498);
      check_val("frame_cnt_wrap", sample_cnt, 0);

      // backpressure with three pairs in flight
      out_ready = 1'b0;
      send(0, 10, 12);
      send(0, 100, 90);
      send(0, 30, 30);
      @(negedge clk);
      hold = ans;
      check_val("bp_ans_first", ans, 25);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_val("bp_in_ready", in_ready, 0);
         check_val("bp_out_valid", out_valid, 1);
         check_val("bp_ans_hold", ans, hold);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(0, 0, 0);
      drain();

      // reset mid-frame with one score in flight
      send(0, 1, 1);
      send(0, 1, 0);
      send(0, 200, 10);
      wait_cnt(0, 2);
      check_val("mf_inflight", out_valid, 1);
      pulse_rst();
      check_val("mf_out_valid", out_valid, 0);
      check_val("mf_sample_cnt", sample_cnt, 0);
      check_val("mf_frame_sum_clr", frame_sum, 0);
      send(0, 1, 1);
      send(0, 1, 0);
      send(0, 200, 10);
      send(0, 250, 249);
      drain();
      check_val("mf_frame_498", frame_sum, 498);

      // 12-bit variant: score, reset mid-frame, fresh frame
      send(1, 4000, 3990);
      wait_out(1, lat);
      check_val("w12_latency", lat, 3);
      check_val("w12_ans_4070", b_ans, 4070);
      send(1, 10, 20);
      wait_cnt(1, 2);
      pulse_rst();
      check_val("w12_mf_cnt", b_sample_cnt, 0);
      check_val("w12_mf_out_valid", b_out_valid, 0);
      send(1, 4000, 3990);
      send(1, 10, 20);
      send(1, 0, 4095);
      drain();
      check_val("w12_frame_8255", b_frame_sum, 8255);
      check_val("w12_cnt_wrap", b_sample_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
